// File: rtl/imm_pkg.sv
// Shared RISC-V immediate-decode definitions: format codes, major opcodes, XLEN legality.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Combinational instruction-format classifier and immediate extractor, no state.
// Illegal encodings collapse to fmt NONE with a zero immediate.
module imm_decode_core
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_EN = 1
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [31:0] imm32;
    logic        sext;

    always_comb begin
        imm32     = '0;
        sext      = 1'b1;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (inst_i[6:0])
            OPC_OP: fmt_o = FMT_R;
            OPC_OP_32: begin
                if (XLEN == 64) fmt_o = FMT_R;
                else            illegal_o = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                fmt_o = FMT_I;
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt_o = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                // funct3[2] distinguishes the CSR-immediate forms (csrrwi/csrrsi/csrrci)
                if ((CSR_EN != 0) && inst_i[14]) begin
                    fmt_o = FMT_CSR;
                    imm32 = {27'b0, inst_i[19:15]};
                    sext  = 1'b0;
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            default: illegal_o = 1'b1;
        endcase

        if (inst_i[1:0] != 2'b11) illegal_o = 1'b1;

        if (illegal_o) begin
            fmt_o = FMT_NONE;
            imm32 = '0;
        end

        if (sext) imm_o = XLEN'($signed(imm32));
        else      imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: combinational decode into a 2-entry skid FIFO, registered outputs, latency 1.
// in_ready drops only when both entries are held; out_* stay stable while out_ready is low.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{inst: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t dec_entry;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            push;
    logic            pop;

    imm_decode_core #(
        .XLEN   (XLEN),
        .CSR_EN (CSR_EN)
    ) u_core (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign dec_entry = '{inst: in_inst, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    assign in_ready  = (state_q != ST_FULL) & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = dec_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = dec_entry;
                    end else if (push) begin
                        skid_d  = dec_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_inst    = head_q.inst;
    assign out_pc      = head_q.pc;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench driving an XLEN=32 and an XLEN=64 instance with identical stimulus.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] inst32, pc32, imm32;
    logic [2:0]  fmt32;
    logic        rdy64, vld64, ill64;
    logic [31:0] inst64;
    logic [63:0] pc64, imm64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CSR_EN(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
        .out_inst(inst32), .out_pc(pc32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32)
    );

    imm_decode_stage #(.XLEN(64), .CSR_EN(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
        .out_inst(inst64), .out_pc(pc64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm_32;
        logic [2:0]  fmt_32;
        logic        ill_32;
        logic [63:0] imm_64;
        logic [2:0]  fmt_64;
        logic        ill_64;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = '{
            '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}, // addi -1
            '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0}, // lui
            '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0}, // beq -4
            '{32'h3002D0F3, 32'h00000005, 3'd6, 1'b0, 64'h0000000000000005, 3'd6, 1'b0}, // csrrwi
            '{32'h00000000, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1}, // zero word
            '{32'h00112623, 32'h0000000C, 3'd2, 1'b0, 64'h000000000000000C, 3'd2, 1'b0}, // sw 12
            '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0}, // jal 8
            '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0}, // add
            '{32'h0010009B, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000001, 3'd1, 1'b0}, // addiw 1
            '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0}, // ecall
            '{32'h00000001, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1}  // compressed
        };

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #1;
        chk("rst_vld32", vld32, 0);
        chk("rst_rdy32", rdy32, 0);
        chk("rst_rdy64", rdy64, 0);
        chk("rst_fmt32", fmt32, 7);
        chk("rst_imm64", imm64, 0);
        chk("rst_inst32", inst32, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy32", rdy32, 1);
        chk("post_rst_rdy64", rdy64, 1);
        chk("post_rst_vld64", vld64, 0);

        // back-to-back stream: each vector appears one edge after it is offered
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_inst   = vecs[i].inst;
            in_pc     = 64'h8000_0000_0000_1000 + 64'(4 * i);
            out_ready = 1'b1;
            step();
            chk($sformatf("v%0d_vld32", i), vld32, 1);
            chk($sformatf("v%0d_rdy32", i), rdy32, 1);
            chk($sformatf("v%0d_inst32", i), inst32, vecs[i].inst);
            chk($sformatf("v%0d_pc32", i), pc32, 32'h0000_1000 + 32'(4 * i));
            chk($sformatf("v%0d_imm32", i), imm32, vecs[i].imm_32);
            chk($sformatf("v%0d_fmt32", i), fmt32, vecs[i].fmt_32);
            chk($sformatf("v%0d_ill32", i), ill32, vecs[i].ill_32);
            chk($sformatf("v%0d_pc64", i), pc64, 64'h8000_0000_0000_1000 + 64'(4 * i));
            chk($sformatf("v%0d_imm64", i), imm64, vecs[i].imm_64);
            chk($sformatf("v%0d_fmt64", i), fmt64, vecs[i].fmt_64);
            chk($sformatf("v%0d_ill64", i), ill64, vecs[i].ill_64);
        end
        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("drain_vld32", vld32, 0);
        chk("drain_vld64", vld64, 0);

        // backpressure: A,B accepted, C stalls, then drained in order
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 64'h100;
        step();
        chk("bp_A_vld", vld32, 1);
        chk("bp_A_rdy", rdy32, 1);
        chk("bp_A_inst", inst32, 32'h00A00093);
        @(negedge clk);
        in_inst = 32'h00B00093; in_pc = 64'h104;
        step();
        chk("bp_B_rdy", rdy32, 0);
        chk("bp_B_rdy64", rdy64, 0);
        chk("bp_B_hold_inst", inst32, 32'h00A00093);
        @(negedge clk);
        in_inst = 32'h00C00093; in_pc = 64'h108;
        step();
        chk("bp_C_hold_inst", inst64, 32'h00A00093);
        chk("bp_C_hold_imm", imm32, 32'h0000000A);
        chk("bp_C_hold_pc", pc32, 32'h100);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("bp_pop_B_inst", inst32, 32'h00B00093);
        chk("bp_pop_B_imm", imm64, 64'h0B);
        chk("bp_pop_B_rdy", rdy32, 1);
        step();
        chk("bp_pop_C_inst", inst32, 32'h00C00093);
        chk("bp_pop_C_pc", pc64, 64'h108);
        chk("bp_pop_C_vld", vld32, 1);
        @(negedge clk);
        in_valid = 1'b0;
        step();
        chk("bp_empty_vld", vld32, 0);

        // flush while FULL with a competing push
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
        step();
        @(negedge clk);
        in_inst = 32'h00200093;
        step();
        chk("fl_full_rdy", rdy32, 0);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00300093;
        step();
        chk("fl_vld32", vld32, 0);
        chk("fl_vld64", vld64, 0);
        chk("fl_rdy", rdy32, 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl_dropped", vld32, 0);

        // flush in EMPTY with in_valid must not capture the input
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00400093;
        step();
        chk("fl_empty_vld", vld64, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // reset mid-operation discards buffered entries
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093;
        step();
        chk("mr_loaded", vld32, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_vld", vld32, 0);
        chk("mr_rdy", rdy32, 0);
        chk("mr_inst", inst32, 0);
        chk("mr_fmt", fmt64, 7);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("mr_after_vld", vld32, 0);
        chk("mr_after_rdy", rdy32, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: immediate/PC width; legal values 32, 64.
REQ-002 SHALL have parameter CSR_EN, default 1: 1 = decode SYSTEM zimm (CSR-immediate) format; 0 = treat those encodings as I.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1: synchronous pipeline flush.
REQ-006 SHALL have port in_valid, input, 1: upstream instruction valid.
REQ-007 SHALL have port in_ready, output, 1: stage can accept.
REQ-008 SHALL have port in_inst, input, 32: raw instruction.
REQ-009 SHALL have port in_pc, input, XLEN: instruction PC.
REQ-010 SHALL have port out_valid, output, 1: decoded entry valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_inst, output, 32: instruction passthrough.
REQ-013 SHALL have port out_pc, output, XLEN: PC passthrough.
REQ-014 SHALL have port out_imm, output, XLEN: extended immediate.
REQ-015 SHALL have port out_fmt, output, 3: R=0, I=1, S=2, B=3, U=4, J=5, CSR=6, NONE=7.
REQ-016 SHALL have port out_illegal, output, 1: unrecognised opcode.

Function
REQ-017 SHALL decode opcode inst[6:0]: OP/OP-32 -> R; OP-IMM/OP-IMM-32/LOAD/JALR/MISC-MEM -> I; STORE -> S; BRANCH -> B; LUI/AUIPC -> U; JAL -> J; SYSTEM -> I, or CSR when CSR_EN=1 and funct3[2]=1.
REQ-018 SHALL sign-extend I/S/B/J/U immediates from inst[31] to XLEN; U = {inst[31:12],12'b0} sign-extended; B and J bit 0 = 0.
REQ-019 SHALL set R immediate = 0 and CSR immediate = zero-extended inst[19:15].
REQ-020 SHALL flag illegal when inst[1:0] != 2'b11 or opcode is unlisted; OP-32/OP-IMM-32 are illegal when XLEN=32; illegal entries SHALL carry fmt NONE, imm 0 and still flow through.
REQ-021 SHALL decode combinationally at the input and store results in a 2-entry FIFO skid buffer; out_* SHALL be driven from registers only.
REQ-022 SHALL use occupancy states EMPTY(0), ONE(1), FULL(2); push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-023 SHALL drive in_ready = (state != FULL) & !rst, from registered state only, and out_valid = (state != EMPTY).
REQ-024 SHALL present an input accepted in EMPTY on out_* at the next clock edge (latency 1); back-to-back throughput 1/cycle when out_ready=1.
REQ-025 SHALL, on simultaneous push and pop in ONE or FULL, hold occupancy and preserve FIFO order; FULL with pop and no push -> ONE.
REQ-026 SHALL, with out_valid=1 and out_ready=0, hold all out_* stable.
REQ-027 SHALL, on flush=1, set state EMPTY at the next edge, ignore in_valid that cycle, and not count an out_valid&out_ready that cycle as a pop.

Reset
REQ-028 SHALL, while rst=1, set state EMPTY, out_valid 0, in_ready 0, and out_inst/out_pc/out_imm/out_illegal 0, out_fmt NONE; in_ready SHALL be 1 in the first cycle after release.
REQ-029 SHALL, on rst mid-operation, discard all buffered entries without emitting them.

Structure
REQ-030 SHALL put the fmt encoding, opcode constants and XLEN-legal check in shared package imm_pkg.
REQ-031 SHALL place decode logic in combinational sub-module imm_decode_core (XLEN, CSR_EN parameters) reusable by other stages.

Verification
REQ-032 SHALL cover: XLEN=64, 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm 0xFFFFFFFFFFFFFFFF, fmt I.
REQ-033 SHALL cover: 0x800000B7 (lui) -> out_imm 0x80000000 at XLEN=32, 0xFFFFFFFF80000000 at XLEN=64, fmt U.
REQ-034 SHALL cover: 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFC, fmt B; 0x3002D0F3 (csrrwi) -> out_imm 5, fmt CSR.
REQ-035 SHALL cover: out_ready=0, push A,B,C -> A,B accepted, in_ready 0 after B; out_ready=1 -> outputs A,B,C in order, no loss or duplication.
REQ-036 SHALL cover: FULL plus in_valid=1 and flush=1 -> next cycle out_valid 0, input dropped; 0x00000000 -> out_illegal 1, fmt NONE, imm 0.
